// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 encodings and load/store unit state type
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT_RSP, DONE} lsu_state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign/zero-extends it
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = offset == 2'd0 ? rdata[7:0] : offset == 2'd1 ? rdata[15:8] :
        offset == 2'd2 ? rdata[23:16] : rdata[31:24];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    result = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_BU ? {24'b0, b} :
             funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: M-stage load/store unit driving a valid/ready data-memory bus
module memory_access_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] M_alu_result,
  input  logic [31:0] M_write_data,
  input  logic        M_mem_read,
  input  logic        M_mem_write,
  input  logic [2:0]  M_funct3,
  output logic [31:0] M_read_data,
  output logic        M_stall,
  output logic        M_misaligned,
  output logic        M_bus_error,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata
);
  lsu_state_t  state;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        err_q;
  logic        req;
  logic        bad;
  logic        access;
  logic [3:0]  strb_base;
  logic [31:0] ext;
  load_extend u_ext (
    .rdata  (rdata_q),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ext)
  );
  assign req = M_mem_read | M_mem_write;
  // Unsized funct3 values and unsigned variants on stores are illegal alongside alignment faults
  assign bad = M_funct3 == 3'b011 || M_funct3 == 3'b110 || M_funct3 == 3'b111 ||
               (M_mem_write && M_funct3[2]) ||
               (M_funct3[1:0] == 2'b01 && M_alu_result[0]) ||
               (M_funct3[1:0] == 2'b10 && M_alu_result[1:0] != 2'b00);
  assign M_misaligned = req & bad;
  assign access = req & !bad;
  assign dmem_req_valid = state == IDLE && access;
  assign M_stall = dmem_req_valid || state == WAIT_RSP;
  assign dmem_addr = dmem_req_valid ? {M_alu_result[31:2], 2'b00} : 32'b0;
  assign dmem_we = dmem_req_valid & M_mem_write;
  assign strb_base = M_funct3[1:0] == 2'b00 ? 4'b0001 : M_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
  assign dmem_wstrb = dmem_we ? strb_base << M_alu_result[1:0] : 4'b0;
  assign dmem_wdata = !dmem_req_valid ? 32'b0 :
                      M_funct3[1:0] == 2'b00 ? {4{M_write_data[7:0]}} :
                      M_funct3[1:0] == 2'b01 ? {2{M_write_data[15:0]}} : M_write_data;
  assign M_read_data = state == DONE ? ext : 32'b0;
  assign M_bus_error = state == DONE && err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      rdata_q <= 32'b0;
      off_q   <= 2'b0;
      f3_q    <= 3'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dmem_req_valid && dmem_req_ready) begin
          state <= WAIT_RSP;
          off_q <= M_alu_result[1:0];
          f3_q  <= M_funct3;
          err_q <= 1'b0;
          cnt   <= 8'd0;
        end
        WAIT_RSP: if (dmem_rsp_valid) begin
          rdata_q <= dmem_rdata;
          state   <= DONE;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          rdata_q <= 32'b0;
          err_q   <= 1'b1;
          state   <= DONE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: vector table, corner sequences and randomized checks against a reference model
module tb_memory_access_unit;
  logic        clk = 0;
  logic        rst;
  logic [31:0] M_alu_result, M_write_data, M_read_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic        M_mem_read, M_mem_write, M_stall, M_misaligned, M_bus_error;
  logic [2:0]  M_funct3;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [3:0]  dmem_wstrb;
  int checks = 0;
  int errors = 0;

  memory_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .M_alu_result(M_alu_result), .M_write_data(M_write_data),
    .M_mem_read(M_mem_read), .M_mem_write(M_mem_write), .M_funct3(M_funct3),
    .M_read_data(M_read_data), .M_stall(M_stall), .M_misaligned(M_misaligned),
    .M_bus_error(M_bus_error), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdt;
    int          rdly, sdly;
    logic        em;
    logic [3:0]  es;
    logic [31:0] ew, erd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    M_mem_read = 0; M_mem_write = 0; M_funct3 = 0; M_alu_result = 0; M_write_data = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
  endtask

  // Reference: access size from funct3, lanes and extension from plain byte arithmetic
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
                                output logic em, output logic [3:0] es,
                                output logic [31:0] ew, output logic [31:0] erd);
    int nb, off;
    logic bad;
    longint v;
    nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    off = int'(a % 4);
    bad = (f3 == 3 || f3 == 6 || f3 == 7) || (wr && f3 >= 4) || (off % nb != 0);
    em = (rd || wr) && bad;
    es = wr ? 4'(((1 << nb) - 1) << off) : 4'd0;
    for (int i = 0; i < 4; i++) ew[8*i +: 8] = wd[8*(i % nb) +: 8];
    v = longint'(rdt) >> (8 * off);
    if (nb < 4) v = v % (longint'(1) << (8 * nb));
    if (f3 < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    erd = 32'(v);
  endfunction

  task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
                         input int rdly, input int sdly, input logic em, input logic [3:0] es,
                         input logic [31:0] ew, input logic [31:0] erd);
    M_mem_read = rd; M_mem_write = wr; M_funct3 = f3; M_alu_result = a; M_write_data = wd;
    dmem_rdata = rdt; dmem_req_ready = 0; dmem_rsp_valid = 0;
    #1;
    chk({tag, ".misaligned"}, 32'(M_misaligned), 32'(em));
    if (!(rd || wr) || em) begin
      chk({tag, ".noreq_valid"}, 32'(dmem_req_valid), 0);
      chk({tag, ".noreq_stall"}, 32'(M_stall), 0);
      step();
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        dmem_req_ready = (i == rdly);
        #1;
        chk({tag, ".req_valid"}, 32'(dmem_req_valid), 1);
        chk({tag, ".req_stall"}, 32'(M_stall), 1);
        chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
        chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(es));
        if (wr) chk({tag, ".wdata"}, dmem_wdata, ew);
        step();
      end
      dmem_req_ready = 0;
      for (int i = 0; i <= sdly; i++) begin
        dmem_rsp_valid = (i == sdly);
        #1;
        chk({tag, ".wait_stall"}, 32'(M_stall), 1);
        chk({tag, ".wait_valid"}, 32'(dmem_req_valid), 0);
        step();
      end
      dmem_rsp_valid = 0;
      #1;
      chk({tag, ".done_stall"}, 32'(M_stall), 0);
      chk({tag, ".done_err"}, 32'(M_bus_error), 0);
      if (rd) chk({tag, ".rdata"}, M_read_data, erd);
      step();
    end
    clear_inputs();
    #1;
    chk({tag, ".idle_stall"}, 32'(M_stall), 0);
  endtask

  initial begin
    logic        rd, wr, em;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdt, ew, erd;
    logic [3:0]  es;
    int          op;
    rst = 1;
    clear_inputs();
    dmem_rdata = 0;
    step();
    step();
    chk("reset.stall", 32'(M_stall), 0);
    chk("reset.req_valid", 32'(dmem_req_valid), 0);
    chk("reset.read_data", M_read_data, 0);
    chk("reset.bus_error", 32'(M_bus_error), 0);
    chk("reset.addr", dmem_addr, 0);
    rst = 0;
    step();

    vecs.push_back('{0, 1, 3'd0, 32'h1003, 32'h000000AB, 32'h0, 0, 0, 0, 4'b1000, 32'hABABABAB, 32'h0});
    vecs.push_back('{1, 0, 3'd1, 32'h2002, 32'h0, 32'h80011234, 0, 0, 0, 4'b0000, 32'h0, 32'hFFFF8001});
    vecs.push_back('{1, 0, 3'd5, 32'h2002, 32'h0, 32'h80011234, 0, 0, 0, 4'b0000, 32'h0, 32'h00008001});
    vecs.push_back('{1, 0, 3'd2, 32'h1001, 32'h0, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{0, 1, 3'd2, 32'h0100, 32'h12345678, 32'h0, 3, 1, 0, 4'b1111, 32'h12345678, 32'h0});
    vecs.push_back('{1, 0, 3'd0, 32'h0101, 32'h0, 32'h00008000, 0, 0, 0, 4'b0000, 32'h0, 32'hFFFFFF80});
    vecs.push_back('{1, 0, 3'd4, 32'h0101, 32'h0, 32'h00008000, 0, 0, 0, 4'b0000, 32'h0, 32'h00000080});
    vecs.push_back('{0, 1, 3'd1, 32'h0102, 32'h0000BEEF, 32'h0, 0, 0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0});
    vecs.push_back('{1, 0, 3'd3, 32'h0000, 32'h0, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{0, 1, 3'd4, 32'h0000, 32'h0, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1, 0, 3'd1, 32'h0003, 32'h0, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1, 0, 3'd2, 32'h0204, 32'h0, 32'hCAFEBABE, 1, 2, 0, 4'b0000, 32'h0, 32'hCAFEBABE});
    vecs.push_back('{1, 0, 3'd0, 32'h0007, 32'h0, 32'h7F000000, 0, 0, 0, 4'b0000, 32'h0, 32'h0000007F});
    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd,
              vecs[i].rdt, vecs[i].rdly, vecs[i].sdly, vecs[i].em, vecs[i].es, vecs[i].ew, vecs[i].erd);

    // Timeout: previous load left nonzero captured data, so a zero result shows the forced clear
    M_mem_read = 1; M_funct3 = 3'd2; M_alu_result = 32'h40; dmem_rdata = 32'hDEADBEEF;
    dmem_req_ready = 1;
    #1;
    chk("tmo.req_valid", 32'(dmem_req_valid), 1);
    step();
    dmem_req_ready = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo.wait%0d_stall", i), 32'(M_stall), 1);
      chk($sformatf("tmo.wait%0d_err", i), 32'(M_bus_error), 0);
      step();
    end
    chk("tmo.done_err", 32'(M_bus_error), 1);
    chk("tmo.done_rdata", M_read_data, 0);
    chk("tmo.done_stall", 32'(M_stall), 0);
    clear_inputs();
    step();
    chk("tmo.after_err", 32'(M_bus_error), 0);

    // Reset in WAIT_RSP, then a stray response must be ignored
    M_mem_read = 1; M_funct3 = 3'd2; M_alu_result = 32'h80; dmem_req_ready = 1;
    step();
    dmem_req_ready = 0;
    step();
    chk("rstw.stall_before", 32'(M_stall), 1);
    rst = 1;
    clear_inputs();
    step();
    chk("rstw.stall", 32'(M_stall), 0);
    chk("rstw.req_valid", 32'(dmem_req_valid), 0);
    chk("rstw.read_data", M_read_data, 0);
    chk("rstw.bus_error", 32'(M_bus_error), 0);
    rst = 0;
    dmem_rsp_valid = 1; dmem_rdata = 32'h12345678;
    step();
    dmem_rsp_valid = 0;
    chk("rstw.ign_stall", 32'(M_stall), 0);
    chk("rstw.ign_rdata", M_read_data, 0);
    step();
    chk("rstw.ign_rdata2", M_read_data, 0);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      rd = (op == 1);
      wr = (op == 2);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      rdt = $urandom;
      model(rd, wr, f3, a, wd, rdt, em, es, ew, erd);
      run_txn($sformatf("rnd%0d", n), rd, wr, f3, a, wd, rdt, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), em, es, ew, erd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
